state_vector_uart_tx: RTL

- Transmit end for the Kalman filter state estimate.
- On a start pulse (driven from the filter FSM's wait-to-send state), snapshots the nos-word State vector.
- Serialises the snapshot as one framed UART packet (8N1) for the host link, then reports done so the filter can take the next sample.

---
 rtl/kf_pkg.sv | 18 +
 rtl/uart_byte_tx.sv | 114 +++++++++++
 rtl/state_vector_uart_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/kf_pkg.sv
// Shared types and helpers for the Kalman filter state-vector UART transmitter.
// Holds the byte-level FSM encoding, the default sync byte and the word-to-byte sizing.
package kf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 serialiser with down-counting baud and bit timers.
// ready goes high in IDLE and on the last enabled cycle of a stop bit, so bytes chain with no gap.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte
//   START | driving the start bit (0)
//   DATA  | shifting 8 data bits, LSB first
//   STOP  | driving the stop bit (1)
module uart_byte_tx
  import kf_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  tx_state_e     state_nxt;
  logic [BW-1:0] baud;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_tc;
  logic          bit_tc;
  logic          load;

  assign baud_tc = (baud == '0);
  assign bit_tc  = (bit_cnt == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clk_en) begin
      case (state)
        IDLE:    if (valid) state_nxt = START;
        START:   if (baud_tc) state_nxt = DATA;
        DATA:    if (baud_tc && bit_tc) state_nxt = STOP;
        STOP:    if (baud_tc) state_nxt = valid ? START : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready = (state == IDLE) || ((state == STOP) && baud_tc);
    load  = clk_en && valid && ready;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx      <= 1'b1;
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (clk_en) begin
      if (load) begin
        shreg <= data;
        tx    <= 1'b0;
        baud  <= BAUD_LAST;
      end else begin
        case (state)
          START: begin
            if (baud_tc) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= 3'd7;
              baud    <= BAUD_LAST;
            end else begin
              baud <= baud - BW'(1);
            end
          end
          DATA: begin
            if (baud_tc) begin
              baud <= BAUD_LAST;
              if (bit_tc) begin
                tx <= 1'b1;
              end else begin
                tx      <= shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else begin
              baud <= baud - BW'(1);
            end
          end
          STOP: begin
            if (baud_tc) begin
              tx <= 1'b1;
            end else begin
              baud <= baud - BW'(1);
            end
          end
          default: tx <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: rtl/state_vector_uart_tx.sv
// Packetises a snapshot of the filter state vector as HEADER, payload bytes, XOR checksum.
// Holds the snapshot, byte index, checksum and the done/overrun handshake pulses.
module state_vector_uart_tx
  import kf_pkg::*;
#(
  parameter int         WIDTH        = 16,
  parameter int         nos          = 4,
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             start,
  input  logic [WIDTH-1:0] State [0:nos-1],
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int SW    = BPW * 8;
  localparam int NP    = nos * BPW;
  localparam int NB    = NP + 2;
  localparam int IW    = $clog2(NB);
  localparam int NSLOT = 1 << IW;
  localparam logic [IW-1:0] IDX_LAST = IW'(NB - 1);
  localparam logic [IW-1:0] IDX_PRE_CHK = IW'(NB - 2);

  logic [SW-1:0] snap [nos];
  logic [7:0]    payload [NSLOT];
  logic [IW-1:0] idx;
  logic [7:0]    chk;
  logic          byte_ready;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          accept;
  logic          byte_end;
  logic          last;
  logic          finish;
  logic          advance;

  // Flattened MSB-first byte view of the snapshot; spare slots stay zero.
  always_comb begin
    for (int s = 0; s < NSLOT; s++) payload[s] = '0;
    for (int w = 0; w < nos; w++) begin
      for (int b = 0; b < BPW; b++) begin
        payload[w*BPW + b] = snap[w][8*(BPW-1-b) +: 8];
      end
    end
  end

  always_comb begin
    accept     = clk_en && start && !busy;
    byte_end   = clk_en && busy && byte_ready;
    last       = (idx == IDX_LAST);
    finish     = byte_end && last;
    advance    = byte_end && !last;
    byte_valid = accept || advance;
    if (accept) begin
      byte_data = HEADER;
    end else if (idx == IDX_PRE_CHK) begin
      byte_data = chk;
    end else begin
      byte_data = payload[idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= 1'b0;
      idx     <= '0;
      chk     <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < nos; i++) snap[i] <= '0;
    end else begin
      done    <= finish;
      overrun <= clk_en && start && busy && !finish;
      if (accept) begin
        busy <= 1'b1;
        idx  <= '0;
        chk  <= '0;
        for (int i = 0; i < nos; i++) snap[i] <= SW'(State[i]);
      end else if (advance) begin
        idx <= idx + IW'(1);
        if (idx != IDX_PRE_CHK) chk <= chk ^ payload[idx];
      end else if (finish) begin
        busy <= 1'b0;
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .valid  (byte_valid),
    .data   (byte_data),
    .tx     (tx),
    .ready  (byte_ready)
  );

endmodule
